// File: rtl/sad_pkg.sv
// Shared types, width helpers and constants for the block-level SAD search.
package sad_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Wide enough for any ACC_W this block can derive; sliced down at use.
    localparam logic [31:0] BEST_SAD_INIT = 32'hFFFF_FFFF;

    function automatic int acc_width(input int in_w, input int blk_len);
        return in_w + $clog2(blk_len);
    endfunction

    function automatic int idx_width(input int num_cand);
        return (num_cand > 1) ? $clog2(num_cand) : 1;
    endfunction

endpackage

// File: rtl/sad_block_search_if.sv
// Stream, block-strobe and result signals between sad_block_search and its neighbours.
interface sad_block_search_if #(
    parameter int IN_W  = 3,
    parameter int ACC_W = sad_pkg::acc_width(3, 16),
    parameter int IDX_W = sad_pkg::idx_width(8)
);
    logic             start;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sad;
    logic             blk_valid;
    logic [ACC_W-1:0] blk_sad;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_min_sad;
    logic [IDX_W-1:0] out_best_idx;

    modport slave (
        input  start, in_valid, in_sad, out_ready,
        output busy, in_ready, blk_valid, blk_sad, out_valid, out_min_sad, out_best_idx
    );

    modport master (
        output start, in_valid, in_sad, out_ready,
        input  busy, in_ready, blk_valid, blk_sad, out_valid, out_min_sad, out_best_idx
    );
endinterface

// File: rtl/sad_min_tracker.sv
// Running minimum of block SADs; strict less-than so ties keep the earlier index.
module sad_min_tracker
    import sad_pkg::*;
#(
    parameter int ACC_W = 7,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd,
    input  logic [ACC_W-1:0] sum,
    input  logic [IDX_W-1:0] idx,
    output logic [ACC_W-1:0] best_sad_nxt,
    output logic [IDX_W-1:0] best_idx_nxt
);
    logic [ACC_W-1:0] best_sad_q, best_sad_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;

    always_comb begin
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;
        if (clr) begin
            best_sad_d = BEST_SAD_INIT[ACC_W-1:0];
            best_idx_d = {IDX_W{1'b0}};
        end else if (upd && (sum < best_sad_q)) begin
            best_sad_d = sum;
            best_idx_d = idx;
        end else begin
            best_sad_d = best_sad_q;
            best_idx_d = best_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_sad_q <= {ACC_W{1'b0}};
            best_idx_q <= {IDX_W{1'b0}};
        end else begin
            best_sad_q <= best_sad_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign best_sad_nxt = best_sad_d;
    assign best_idx_nxt = best_idx_d;
endmodule

// File: rtl/sad_block_search.sv
// Accumulates per-pixel SADs into per-candidate block SADs and reports the best candidate.
module sad_block_search
    import sad_pkg::*;
#(
    parameter int IN_W     = 3,
    parameter int BLK_LEN  = 16,
    parameter int NUM_CAND = 8
) (
    input logic               clk,
    input logic               rst,
    sad_block_search_if.slave bus
);
    localparam int ACC_W = acc_width(IN_W, BLK_LEN);
    localparam int IDX_W = idx_width(NUM_CAND);
    localparam int SC_W  = $clog2(BLK_LEN);

    state_t           state_q, state_d;
    logic [SC_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [IDX_W-1:0] cand_cnt_q, cand_cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             blk_valid_q, blk_valid_d;
    logic [ACC_W-1:0] blk_sad_q, blk_sad_d;
    logic [ACC_W-1:0] out_min_sad_q, out_min_sad_d;
    logic [IDX_W-1:0] out_best_idx_q, out_best_idx_d;

    logic             hs_s, blk_end_s, last_s, clr_s;
    logic [ACC_W-1:0] sum_s, trk_sad_s;
    logic [IDX_W-1:0] trk_idx_s;

    assign hs_s      = (state_q == ST_ACCUM) && bus.in_valid;
    assign sum_s     = acc_q + {{(ACC_W-IN_W){1'b0}}, bus.in_sad};
    assign blk_end_s = hs_s && (sample_cnt_q == SC_W'(BLK_LEN - 1));
    assign last_s    = blk_end_s && (cand_cnt_q == IDX_W'(NUM_CAND - 1));
    assign clr_s     = (state_q == ST_IDLE) && bus.start;

    sad_min_tracker #(.ACC_W(ACC_W), .IDX_W(IDX_W)) u_min (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr_s),
        .upd          (blk_end_s),
        .sum          (sum_s),
        .idx          (cand_cnt_q),
        .best_sad_nxt (trk_sad_s),
        .best_idx_nxt (trk_idx_s)
    );

    always_comb begin
        state_d        = state_q;
        sample_cnt_d   = sample_cnt_q;
        cand_cnt_d     = cand_cnt_q;
        acc_d          = acc_q;
        blk_valid_d    = 1'b0;
        blk_sad_d      = blk_sad_q;
        out_min_sad_d  = out_min_sad_q;
        out_best_idx_d = out_best_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_ACCUM;
                    sample_cnt_d = {SC_W{1'b0}};
                    cand_cnt_d   = {IDX_W{1'b0}};
                    acc_d        = {ACC_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (blk_end_s) begin
                    acc_d        = {ACC_W{1'b0}};
                    sample_cnt_d = {SC_W{1'b0}};
                    blk_valid_d  = 1'b1;
                    blk_sad_d    = sum_s;
                    // Result registers take the tracker's post-update value so they are
                    // already correct on the first DONE cycle.
                    if (last_s) begin
                        state_d        = ST_DONE;
                        out_min_sad_d  = trk_sad_s;
                        out_best_idx_d = trk_idx_s;
                    end else begin
                        cand_cnt_d = cand_cnt_q + IDX_W'(1);
                    end
                end else if (hs_s) begin
                    acc_d        = sum_s;
                    sample_cnt_d = sample_cnt_q + SC_W'(1);
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sample_cnt_q   <= {SC_W{1'b0}};
            cand_cnt_q     <= {IDX_W{1'b0}};
            acc_q          <= {ACC_W{1'b0}};
            blk_valid_q    <= 1'b0;
            blk_sad_q      <= {ACC_W{1'b0}};
            out_min_sad_q  <= {ACC_W{1'b0}};
            out_best_idx_q <= {IDX_W{1'b0}};
        end else begin
            state_q        <= state_d;
            sample_cnt_q   <= sample_cnt_d;
            cand_cnt_q     <= cand_cnt_d;
            acc_q          <= acc_d;
            blk_valid_q    <= blk_valid_d;
            blk_sad_q      <= blk_sad_d;
            out_min_sad_q  <= out_min_sad_d;
            out_best_idx_q <= out_best_idx_d;
        end
    end

    assign bus.in_ready     = (state_q == ST_ACCUM);
    assign bus.out_valid    = (state_q == ST_DONE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.blk_valid    = blk_valid_q;
    assign bus.blk_sad      = blk_sad_q;
    assign bus.out_min_sad  = out_min_sad_q;
    assign bus.out_best_idx = out_best_idx_q;
endmodule
